// File: rtl/doodle_motion.sv
// Doodle physics stage: tick generator, horizontal wrap, gravity, bounce, scroll and death.
// Optional DOODLE_INVINCIBLE_EN: the floor bounces the doodle instead of killing it.
module doodle_motion #(
    parameter int SCR_W       = 30,
    parameter int SCR_H       = 30,
    parameter int XW          = 5,
    parameter int YW          = 5,
    parameter int TICK_DIV    = 4,
    parameter int JUMP_V      = 6,
    parameter int GRAV        = 1,
    parameter int VMAX        = 6,
    parameter int SCROLL_LINE = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              left,
    input  logic              right,
    input  logic              plat_below,
    output logic              physics_update,
    output logic [XW-1:0]     doodle_x,
    output logic [YW-1:0]     doodle_y,
    output logic signed [4:0] vel,
    output logic              scroll,
    output logic [YW-1:0]     scroll_amt,
    output logic              dead
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = YW + 2;
    // The clamp line can never sit above the top row of the screen.
    localparam int SL_INT = (SCROLL_LINE < SCR_H - 1) ? SCROLL_LINE : SCR_H - 1;
    localparam logic signed [SW-1:0] SLINE = SW'(SL_INT);
    localparam logic signed [4:0]    VJUMP = 5'(JUMP_V);
    localparam logic signed [4:0]    VMIN  = 5'(-VMAX);
    localparam logic signed [4:0]    VGRAV = 5'(GRAV);

    typedef enum logic [1:0] {StIdle, StRising, StFalling, StDead} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic signed [4:0]   vel_q, vel_d;
    logic                scroll_q, scroll_d;
    logic [YW-1:0]       amt_q, amt_d;
    logic                dead_q, dead_d;
    logic signed [SW-1:0] sum;
    logic signed [4:0]   vel_dec;

    assign physics_update = (cnt_q == CW'(TICK_DIV - 1));
    assign sum            = $signed({2'b00, y_q}) + $signed({{(SW-5){vel_q[4]}}, vel_q});
    assign vel_dec        = vel_q - VGRAV;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (physics_update) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            x_q      <= XW'(SCR_W / 2);
            y_q      <= YW'(1);
            vel_q    <= '0;
            scroll_q <= 1'b0;
            amt_q    <= '0;
            dead_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            scroll_q <= scroll_d;
            amt_q    <= amt_d;
            dead_q   <= dead_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vel_d    = vel_q;
        scroll_d = 1'b0;
        amt_d    = '0;
        dead_d   = dead_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vel_d   = VJUMP;
                    state_d = StRising;
                end
            end
            StRising, StFalling: begin
                if (physics_update) begin
                    if (right && !left) begin
                        x_d = (x_q == XW'(SCR_W - 1)) ? '0 : x_q + 1'b1;
                    end else if (left && !right) begin
                        x_d = (x_q == '0) ? XW'(SCR_W - 1) : x_q - 1'b1;
                    end

                    if (state_q == StFalling && plat_below) begin
                        vel_d   = VJUMP;
                        state_d = StRising;
                    end else if (sum[SW-1] || sum == '0) begin
                        y_d = '0;
`ifdef DOODLE_INVINCIBLE_EN
                        vel_d   = VJUMP;
                        state_d = StRising;
`else
                        vel_d   = '0;
                        state_d = StDead;
                        dead_d  = 1'b1;
`endif
                    end else begin
                        if (sum > SLINE) begin
                            y_d      = YW'(SL_INT);
                            scroll_d = 1'b1;
                            amt_d    = YW'(sum - SLINE);
                        end else begin
                            y_d = YW'(sum);
                        end
                        vel_d   = (vel_dec < VMIN) ? VMIN : vel_dec;
                        state_d = vel_d[4] ? StFalling : StRising;
                    end
                end
            end
            StDead: ;
            default: state_d = StIdle;
        endcase
    end

    assign doodle_x   = x_q;
    assign doodle_y   = y_q;
    assign vel        = vel_q;
    assign scroll     = scroll_q;
    assign scroll_amt = amt_q;
    assign dead       = dead_q;

endmodule

// File: tb/tb_doodle_motion.sv
// Bench for doodle_motion: arithmetic reference model checked every cycle plus literal checkpoints.
module tb_doodle_motion;

    localparam int W  = 30;
    localparam int TD = 4;
    localparam int JV = 6;
    localparam int VMX = 6;
    localparam int SL = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       plat_below = 1'b0;
    logic       physics_update;
    logic [4:0] doodle_x;
    logic [4:0] doodle_y;
    logic [4:0] vel;
    logic       scroll;
    logic [4:0] scroll_amt;
    logic       dead;

    doodle_motion dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .left           (left),
        .right          (right),
        .plat_below     (plat_below),
        .physics_update (physics_update),
        .doodle_x       (doodle_x),
        .doodle_y       (doodle_y),
        .vel            (vel),
        .scroll         (scroll),
        .scroll_amt     (scroll_amt),
        .dead           (dead)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 rising, 2 falling, 3 dead; mk = edges since reset.
    int mk = 0, mx = W / 2, my = 1, mv = 0, mode = 0, msc = 0, mamt = 0, mdead = 0;
    int nx, ny, nv, nm, nsc, namt, nd, s;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mk <= 0; mx <= W / 2; my <= 1; mv <= 0; mode <= 0;
            msc <= 0; mamt <= 0; mdead <= 0;
        end else begin
            nx = mx; ny = my; nv = mv; nm = mode; nsc = 0; namt = 0; nd = mdead;
            if (mode == 0) begin
                if (start) begin
                    nv = JV;
                    nm = 1;
                end
            end else if (mode != 3 && (mk % TD) == TD - 1) begin
                if (right && !left) nx = (mx + 1) % W;
                else if (left && !right) nx = (mx + W - 1) % W;
                s = my + mv;
                if (mode == 2 && plat_below) begin
                    nv = JV;
                    nm = 1;
                end else if (s <= 0) begin
                    ny = 0;
`ifdef DOODLE_INVINCIBLE_EN
                    nv = JV;
                    nm = 1;
`else
                    nv = 0;
                    nm = 3;
                    nd = 1;
`endif
                end else begin
                    ny = (s > SL) ? SL : s;
                    if (s > SL) begin
                        nsc = 1;
                        namt = s - SL;
                    end
                    nv = (mv - 1 < -VMX) ? -VMX : mv - 1;
                    nm = (nv < 0) ? 2 : 1;
                end
            end
            mk <= mk + 1; mx <= nx; my <= ny; mv <= nv; mode <= nm;
            msc <= nsc; mamt <= namt; mdead <= nd;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("tick", int'(physics_update), int'((mk % TD) == TD - 1));
        chk("x", int'(doodle_x), mx);
        chk("y", int'(doodle_y), my);
        chk("vel", int'($signed(vel)), mv);
        chk("scroll", int'(scroll), msc);
        chk("scroll_amt", int'(scroll_amt), mamt);
        chk("dead", int'(dead), mdead);
    end

    task automatic step_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (physics_update !== 1'b1 && n < 2 * TD) begin
            @(negedge clk);
            n++;
        end
        chk("tick_seen", int'(physics_update), 1);
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int arc_y[7] = '{7, 12, 16, 19, 20, 20, 20};
    int arc_v[7] = '{5, 4, 3, 2, 1, 0, -1};
    int arc_a[7] = '{0, 0, 0, 0, 1, 1, 0};
    int pulses;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_x", int'(doodle_x), 15);
        chk("rst_y", int'(doodle_y), 1);
        chk("rst_vel", int'($signed(vel)), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_tick", int'(physics_update), 0);

        reset = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #2;
            if (physics_update) pulses++;
        end
        chk("pulse_count", pulses, 3);
        chk("idle_x", int'(doodle_x), 15);
        chk("idle_y", int'(doodle_y), 1);

        // Jump arc into the scroll clamp and over the top.
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            step_tick();
            chk("arc_y", int'(doodle_y), arc_y[i]);
            chk("arc_vel", int'($signed(vel)), arc_v[i]);
            chk("arc_amt", int'(scroll_amt), arc_a[i]);
        end

        step_tick();
        chk("fall_y", int'(doodle_y), 19);
        chk("fall_vel", int'($signed(vel)), -2);
        plat_below = 1'b1;
        step_tick();
        plat_below = 1'b0;
        chk("bounce_y", int'(doodle_y), 19);
        chk("bounce_vel", int'($signed(vel)), 6);
        chk("bounce_scroll", int'(scroll), 0);

        step_tick();
        chk("rebound_amt", int'(scroll_amt), 5);
        repeat (11) step_tick();
        chk("low_y", int'(doodle_y), 5);
        chk("low_vel", int'($signed(vel)), -6);
        step_tick();
        chk("floor_y", int'(doodle_y), 0);
`ifdef DOODLE_INVINCIBLE_EN
        chk("floor_vel", int'($signed(vel)), 6);
        chk("floor_dead", int'(dead), 0);
`else
        chk("floor_vel", int'($signed(vel)), 0);
        chk("floor_dead", int'(dead), 1);
`endif

        start = 1'b1;
        left = 1'b1;
        step_tick();
        start = 1'b0;
        left = 1'b0;
        right = 1'b1;
        step_tick();
        right = 1'b0;
`ifndef DOODLE_INVINCIBLE_EN
        chk("dead_x", int'(doodle_x), 15);
        chk("dead_y", int'(doodle_y), 0);
        chk("dead_hold", int'(dead), 1);
`endif

        // Reset pulse away from a tick edge.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rerst_x", int'(doodle_x), 15);
        chk("rerst_y", int'(doodle_y), 1);
        chk("rerst_vel", int'($signed(vel)), 0);
        chk("rerst_dead", int'(dead), 0);

        // Wrap-around with a platform always underneath.
        plat_below = 1'b1;
        pulse_start();
        right = 1'b1;
        repeat (14) step_tick();
        chk("wrap_29", int'(doodle_x), 29);
        step_tick();
        chk("wrap_0", int'(doodle_x), 0);
        right = 1'b0;
        left = 1'b1;
        step_tick();
        chk("wrap_back", int'(doodle_x), 29);
        right = 1'b1;
        step_tick();
        chk("both_hold", int'(doodle_x), 29);
        chk("alive", int'(dead), 0);
        left = 1'b0;
        right = 1'b0;
        plat_below = 1'b0;

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
